// File: rtl/vga_scan_ctrl_if.sv
// Command, strobe and scan-position signals between vga_scan_ctrl and the pixel source.
interface vga_scan_ctrl_if;
   logic        start;
   logic        stop;
   logic        pix_valid;
   logic        busy;
   logic        pix_en;
   logic [15:0] h_count;
   logic [15:0] v_count;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic        pix_rd;
   logic        frame_start;
   logic        underflow;

   modport master (
      output start, stop, pix_valid,
      input  busy, pix_en, h_count, v_count, hsync, vsync,
      input  video_on, pix_rd, frame_start, underflow
   );

   modport slave (
      input  start, stop, pix_valid,
      output busy, pix_en, h_count, v_count, hsync, vsync,
      output video_on, pix_rd, frame_start, underflow
   );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer: pixel-tick divider, h/v scan counters and a start/stop FSM.
// Pixel-underflow reporting is compiled in when VGA_SCAN_UNDERFLOW_EN is defined.
module vga_scan_ctrl #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic           clk,
   input  logic           rst,
   vga_scan_ctrl_if.slave bus
);
   // state   | meaning
   // S_IDLE  | counters parked at 0, decode outputs inactive
   // S_RUN   | scanning frames continuously
   // S_DRAIN | still scanning; drops to S_IDLE at the end of the current frame
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
   localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
   localparam logic [15:0] HS_BEG   = 16'(H_VISIBLE + H_FRONT);
   localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [15:0] VS_BEG   = 16'(V_VISIBLE + V_FRONT);
   localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [15:0] h_q, h_d;
   logic [15:0] v_q, v_d;
   logic        busy_q, busy_d;
   logic        pix_en_q, pix_en_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        video_q, video_d;
   logic        pix_rd_q, pix_rd_d;
   logic        fs_q, fs_d;
   logic        tick, eof, go;

   always_comb begin
      tick    = (div_q == DIV_LAST);
      eof     = tick && (h_q == H_LAST) && (v_q == V_LAST);
      go      = bus.start && !bus.stop;
      state_d = state_q;
      div_d   = div_q;
      h_d     = h_q;
      v_d     = v_q;
      fs_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_RUN;
               fs_d    = 1'b1;
            end
         end
         S_RUN, S_DRAIN: begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
            if (tick) begin
               if (h_q == H_LAST) begin
                  h_d = 16'd0;
                  v_d = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
               end else begin
                  h_d = h_q + 16'd1;
               end
            end
            // Only a wrap taken in S_RUN announces a new frame; a draining wrap ends the scan.
            if (state_q == S_RUN) begin
               fs_d = eof;
               if (bus.stop) state_d = S_DRAIN;
            end else if (eof) begin
               state_d = S_IDLE;
            end else if (go) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
            div_d   = 16'd0;
            h_d     = 16'd0;
            v_d     = 16'd0;
         end
      endcase

      // Decode from next-state values so the registered outputs line up with the counters.
      busy_d   = (state_d != S_IDLE);
      pix_en_d = busy_d && (div_d == DIV_LAST);
      video_d  = busy_d && (h_d < H_VIS) && (v_d < V_VIS);
      hsync_d  = !(busy_d && (h_d >= HS_BEG) && (h_d < HS_END));
      vsync_d  = !(busy_d && (v_d >= VS_BEG) && (v_d < VS_END));
      pix_rd_d = pix_en_d && video_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         div_q    <= 16'd0;
         h_q      <= 16'd0;
         v_q      <= 16'd0;
         busy_q   <= 1'b0;
         pix_en_q <= 1'b0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         video_q  <= 1'b0;
         pix_rd_q <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         h_q      <= h_d;
         v_q      <= v_d;
         busy_q   <= busy_d;
         pix_en_q <= pix_en_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         video_q  <= video_d;
         pix_rd_q <= pix_rd_d;
         fs_q     <= fs_d;
      end
   end

`ifdef VGA_SCAN_UNDERFLOW_EN
   logic uf_q, uf_d;

   always_comb begin
      uf_d = uf_q;
      if (state_q == S_IDLE && go) begin
         uf_d = 1'b0;
      end else if (state_q != S_IDLE && pix_rd_q && !bus.pix_valid) begin
         uf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) uf_q <= 1'b0;
      else     uf_q <= uf_d;
   end

   assign bus.underflow = uf_q;
`else
   logic unused_pix_valid;
   assign unused_pix_valid = bus.pix_valid;
   assign bus.underflow    = 1'b0;
`endif

   assign bus.busy        = busy_q;
   assign bus.pix_en      = pix_en_q;
   assign bus.h_count     = h_q;
   assign bus.v_count     = v_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.video_on    = video_q;
   assign bus.pix_rd      = pix_rd_q;
   assign bus.frame_start = fs_q;
endmodule
